// File: rtl/mtx_serializer_if.sv
// Handshake bundle for mtx_serializer: FIFO-side word offer/pushback and link-side beat output.
// The serializer connects through the slave modport; the environment drives through master.
interface mtx_serializer_if #(
  parameter int unsigned IOW = 8
);
  logic [63:0]      io_packet;
  logic [7:0]       io_valid;
  logic             io_wait;
  logic [2*IOW-1:0] tx_packet;
  logic             tx_access;
  logic             tx_wait;

  modport master (
    output io_packet, io_valid, tx_wait,
    input  io_wait, tx_packet, tx_access
  );

  modport slave (
    input  io_packet, io_valid, tx_wait,
    output io_wait, tx_packet, tx_access
  );
endinterface

// File: rtl/mtx_serializer.sv
// Transmit width-reduction stage: shifts a 64-bit word out as SDR/DDR beats of selectable width.
// Define MTX_SER_COUNT_EN to build the tx_count beat-cycle counter; otherwise tx_count is tied 0.
module mtx_serializer #(
  parameter int unsigned IOW = 8
) (
  input  logic            io_clk,
  input  logic            nreset,
  input  logic            ddr_mode,
  input  logic            lsbfirst,
  input  logic [1:0]      iowidth,
  mtx_serializer_if.slave bus,
  output logic [31:0]     tx_count
);
  localparam int unsigned Lanes = IOW / 8;

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e           state_q, state_d;
  logic [2*IOW-1:0] tx_packet_q;
  logic             tx_access_q;
  logic [63:0]      shreg_q;
  logic [2:0]       rem_q;
  logic [3:0]       bpb_q;
  logic [4:0]       cpc_q;
  logic             ddr_q;

  logic             offered, io_wait, accept, advance, retire;
  logic [63:0]      ord_new;
  logic [3:0]       bpb_new;
  logic [4:0]       cpc_new;
  logic [2:0]       rem_new;

  // Shift register holds bytes in consumption order, so one cycle is always its lowest bytes.
  function automatic logic [2*IOW-1:0] pack_beats(input logic [63:0] ord, input logic [3:0] bpb,
                                                  input logic ddr);
    logic [63:0] hi_src;
    pack_beats = '0;
    hi_src     = ddr ? (ord >> {bpb, 3'b000}) : ord;
    for (int j = 0; j < int'(Lanes); j++) begin
      if (4'(j) < bpb) begin
        pack_beats[8*j +: 8]       = ord[8*j +: 8];
        pack_beats[IOW+8*j +: 8]   = hi_src[8*j +: 8];
      end
    end
  endfunction

  always_comb begin
    int n, b, c, k;
    n = 0;
    for (int i = 0; i < 8; i++) n += int'(bus.io_valid[i]);
    ord_new = '0;
    for (int j = 0; j < 8; j++) begin
      if (j < n) begin
        ord_new[8*j +: 8] = lsbfirst ? bus.io_packet[8*j +: 8] : bus.io_packet[8*(n-1-j) +: 8];
      end
    end
    b = 1 << iowidth;
    if (b > int'(Lanes)) b = int'(Lanes);
    c       = ddr_mode ? 2 * b : b;
    k       = (n + c - 1) / c;
    bpb_new = 4'(b);
    cpc_new = 5'(c);
    rem_new = 3'(k - 1);
  end

  always_ff @(posedge io_clk or negedge nreset) begin
    if (!nreset) state_q <= StIdle;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (offered) state_d = StSend;
      StSend:  if (rem_q == 3'd0 && !bus.tx_wait && !offered) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    offered = bus.io_valid != 8'd0;
    io_wait = (state_q == StSend) && !(rem_q == 3'd0 && !bus.tx_wait);
    accept  = offered && !io_wait;
    advance = (state_q == StSend) && !bus.tx_wait && (rem_q != 3'd0);
    retire  = (state_q == StSend) && !bus.tx_wait && (rem_q == 3'd0) && !offered;
  end

  always_ff @(posedge io_clk or negedge nreset) begin
    if (!nreset) begin
      tx_packet_q <= '0;
      tx_access_q <= 1'b0;
      shreg_q     <= '0;
      rem_q       <= '0;
      bpb_q       <= '0;
      cpc_q       <= '0;
      ddr_q       <= 1'b0;
    end else if (accept) begin
      tx_packet_q <= pack_beats(ord_new, bpb_new, ddr_mode);
      tx_access_q <= 1'b1;
      shreg_q     <= ord_new >> {cpc_new, 3'b000};
      rem_q       <= rem_new;
      bpb_q       <= bpb_new;
      cpc_q       <= cpc_new;
      ddr_q       <= ddr_mode;
    end else if (advance) begin
      tx_packet_q <= pack_beats(shreg_q, bpb_q, ddr_q);
      shreg_q     <= shreg_q >> {cpc_q, 3'b000};
      rem_q       <= rem_q - 3'd1;
    end else if (retire) begin
      tx_packet_q <= '0;
      tx_access_q <= 1'b0;
      shreg_q     <= '0;
    end
  end

  assign bus.io_wait   = io_wait;
  assign bus.tx_packet = tx_packet_q;
  assign bus.tx_access = tx_access_q;

`ifdef MTX_SER_COUNT_EN
  logic [31:0] count_q;
  always_ff @(posedge io_clk or negedge nreset) begin
    if (!nreset)                count_q <= '0;
    else if (accept || advance) count_q <= count_q + 32'd1;
  end
  assign tx_count = count_q;
`else
  assign tx_count = '0;
`endif
endmodule

// File: tb/tb_mtx_serializer.sv
// Self-checking bench for mtx_serializer: directed scenarios plus randomized words against a
// queue-based byte-stream reference model.
module tb_mtx_serializer;
  localparam int unsigned IOW   = 32;
  localparam int unsigned LANES = IOW / 8;

  typedef logic [2*IOW-1:0] beat_t;
  typedef struct {
    logic [63:0] pkt;
    logic [7:0]  valid;
    logic        ddr;
    logic        lsb;
    logic [1:0]  iow;
  } word_t;

  logic        io_clk = 1'b0;
  logic        nreset = 1'b0;
  logic        ddr_mode, lsbfirst;
  logic [1:0]  iowidth;
  logic [31:0] tx_count;

  mtx_serializer_if #(.IOW(IOW)) bus ();

  mtx_serializer #(.IOW(IOW)) u_dut (
    .io_clk   (io_clk),
    .nreset   (nreset),
    .ddr_mode (ddr_mode),
    .lsbfirst (lsbfirst),
    .iowidth  (iowidth),
    .bus      (bus.slave),
    .tx_count (tx_count)
  );

  always #5 io_clk = ~io_clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  word_t       src[$];
  bit          wait_script[$];
  int unsigned wait_pct = 0;
  beat_t       exp_cur;
  bit          exp_acc;
  beat_t       exp_pend[$];
  int unsigned exp_cnt;
  beat_t       obs[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: list bytes in send order, then chop into cycles of C bytes.
  function automatic void build(input word_t w);
    byte unsigned bq[$];
    int n, b, c;
    n = $countones(w.valid);
    for (int i = 0; i < n; i++) bq.push_back(w.lsb ? w.pkt[8*i +: 8] : w.pkt[8*(n-1-i) +: 8]);
    b = 1 << w.iow;
    if (b > int'(LANES)) b = int'(LANES);
    c = w.ddr ? 2 * b : b;
    while (bq.size() > 0) begin
      beat_t        v;
      byte unsigned ch[$];
      v = '0;
      for (int i = 0; i < c && bq.size() > 0; i++) ch.push_back(bq.pop_front());
      for (int j = 0; j < b; j++) begin
        if (j < ch.size()) v[8*j +: 8] = ch[j];
        if (w.ddr) begin
          if (b + j < ch.size()) v[IOW+8*j +: 8] = ch[b+j];
        end else if (j < ch.size()) begin
          v[IOW+8*j +: 8] = ch[j];
        end
      end
      exp_pend.push_back(v);
    end
  endfunction

  function automatic word_t rand_word();
    word_t w;
    int    n;
    n       = $urandom_range(1, 8);
    w.pkt   = {$urandom, $urandom};
    w.valid = 8'((16'd1 << n) - 16'd1);
    w.ddr   = 1'($urandom);
    w.lsb   = 1'($urandom);
    w.iow   = 2'($urandom);
    return w;
  endfunction

  task automatic apply_inputs();
    if (src.size() > 0) begin
      bus.io_packet = src[0].pkt;
      bus.io_valid  = src[0].valid;
      ddr_mode      = src[0].ddr;
      lsbfirst      = src[0].lsb;
      iowidth       = src[0].iow;
    end else begin
      bus.io_packet = {$urandom, $urandom};
      bus.io_valid  = 8'h00;
      ddr_mode      = 1'($urandom);
      lsbfirst      = 1'($urandom);
      iowidth       = 2'($urandom);
    end
    if (wait_script.size() > 0) bus.tx_wait = wait_script.pop_front();
    else                        bus.tx_wait = ($urandom_range(99) < wait_pct);
    assert ((bus.io_valid & (bus.io_valid + 8'd1)) == 8'd0);
  endtask

  // Called at posedge+1; returns at the next posedge+1.
  task automatic tick();
    bit exp_wait, offer;
    apply_inputs();
    #2;
    exp_wait = exp_acc && !(exp_pend.size() == 0 && !bus.tx_wait);
    check("io_wait", 64'(bus.io_wait), 64'(exp_wait));
    offer = bus.io_valid != 8'd0;
    @(posedge io_clk);
    if (exp_acc && bus.tx_wait) begin
      // held
    end else if (exp_pend.size() > 0) begin
      exp_cur = exp_pend.pop_front();
      exp_cnt++;
    end else if (offer) begin
      build(src.pop_front());
      exp_cur = exp_pend.pop_front();
      exp_acc = 1'b1;
      exp_cnt++;
    end else begin
      exp_acc = 1'b0;
    end
    #1;
    check("tx_access", 64'(bus.tx_access), 64'(exp_acc));
    if (exp_acc) check("tx_packet", bus.tx_packet, exp_cur);
`ifdef MTX_SER_COUNT_EN
    check("tx_count", 64'(tx_count), 64'(exp_cnt));
`else
    check("tx_count", 64'(tx_count), 64'd0);
`endif
    if (bus.tx_access) obs.push_back(bus.tx_packet);
  endtask

  task automatic drain();
    int guard = 0;
    while ((exp_acc || src.size() > 0) && guard < 400) begin
      tick();
      guard++;
    end
    if (guard >= 400) check("drain_timeout", 64'd1, 64'd0);
    tick();
  endtask

  // Assert reset mid-cycle, check outputs clear at once, release away from the edge.
  task automatic do_reset();
    nreset = 1'b0;
    #1;
    check("rst_access", 64'(bus.tx_access), 64'd0);
    check("rst_packet", bus.tx_packet, 64'd0);
    check("rst_wait", 64'(bus.io_wait), 64'd0);
    check("rst_count", 64'(tx_count), 64'd0);
    src.delete();
    wait_script.delete();
    exp_pend.delete();
    obs.delete();
    exp_acc = 1'b0;
    exp_cur = '0;
    exp_cnt = 0;
    bus.io_valid = 8'h00;
    bus.tx_wait  = 1'b0;
    @(negedge io_clk);
    @(negedge io_clk);
    nreset = 1'b1;
    @(posedge io_clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.io_packet = '0;
    bus.io_valid  = 8'h00;
    bus.tx_wait   = 1'b0;
    ddr_mode      = 1'b0;
    lsbfirst      = 1'b1;
    iowidth       = 2'd0;
    #16;
    do_reset();

    // Single word, SDR, 8-bit beats, lsb first
    src.push_back('{64'h0807060504030201, 8'hFF, 1'b0, 1'b1, 2'd0});
    drain();
    check("t1_beats", 64'(obs.size()), 64'd8);
    for (int i = 0; i < 8 && i < obs.size(); i++) check("t1_byte", 64'(obs[i][7:0]), 64'(i + 1));
    obs.delete();

    // DDR, msb first
    src.push_back('{64'h0807060504030201, 8'hFF, 1'b1, 1'b0, 2'd0});
    drain();
    check("t2_beats", 64'(obs.size()), 64'd4);
    for (int i = 0; i < 4 && i < obs.size(); i++) begin
      check("t2_first", 64'(obs[i][7:0]), 64'(8 - 2 * i));
      check("t2_second", 64'(obs[i][IOW+7:IOW]), 64'(7 - 2 * i));
    end
    obs.delete();

    // Partial word with zero padding, width clamped to the lane
    src.push_back('{64'h1122_3344_55CC_BBAA, 8'h07, 1'b0, 1'b1, 2'd3});
    drain();
    check("t3_beats", 64'(obs.size()), 64'd1);
    if (obs.size() > 0) begin
      check("t3_lo", 64'(obs[0][31:0]), 64'h00CC_BBAA);
      check("t3_hi", 64'(obs[0][63:32]), 64'h00CC_BBAA);
    end
    obs.delete();

    // Back-to-back words with pushback on the last beat of word 1
    wait_script = '{1'b0, 1'b0, 1'b1};
    src.push_back('{64'h0000_0000_0000_BBAA, 8'h03, 1'b0, 1'b1, 2'd0});
    src.push_back('{64'h0000_0000_0000_DDCC, 8'h03, 1'b0, 1'b1, 2'd0});
    drain();
    check("t4_beats", 64'(obs.size()), 64'd5);
    begin
      logic [7:0] t4_exp[5];
      t4_exp = '{8'hAA, 8'hBB, 8'hBB, 8'hCC, 8'hDD};
      for (int i = 0; i < 5 && i < obs.size(); i++) check("t4_byte", 64'(obs[i][7:0]), 64'(t4_exp[i]));
    end
    obs.delete();

    // Reset during beat 3 of an 8-byte word, then a fresh word starts from byte 0
    src.push_back('{64'h1817161514131211, 8'hFF, 1'b0, 1'b1, 2'd0});
    tick();
    tick();
    tick();
    check("t5_beat3", 64'(bus.tx_packet[7:0]), 64'h13);
    do_reset();
    src.push_back('{64'h2827262524232221, 8'hFF, 1'b0, 1'b1, 2'd0});
    drain();
    check("t5_beats", 64'(obs.size()), 64'd8);
    if (obs.size() > 0) check("t5_first", 64'(obs[0][7:0]), 64'h21);

    // Three words at K=4 from a cleared counter
    do_reset();
    for (int i = 0; i < 3; i++) src.push_back('{{$urandom, $urandom}, 8'hFF, 1'b1, 1'b1, 2'd0});
    drain();
`ifdef MTX_SER_COUNT_EN
    check("count12", 64'(tx_count), 64'd12);
`else
    check("count12", 64'(tx_count), 64'd0);
`endif

    // Randomized words, configs and link pushback
    wait_pct = 25;
    for (int r = 0; r < 60; r++) begin
      int nw = $urandom_range(1, 3);
      for (int i = 0; i < nw; i++) src.push_back(rand_word());
      drain();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
